// File: rtl/router_0_out_arbiter.sv
// Per-output round-robin arbiter and crossbar mux for router output port 0.
// Optional packet counter enabled by defining ARB_PKT_CNT_EN.
module router_0_out_arbiter #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Lreq,
   input  logic                  Ereq,
   input  logic                  Sreq,
   input  logic [DATA_WIDTH-1:0] Ldata,
   input  logic [DATA_WIDTH-1:0] Edata,
   input  logic [DATA_WIDTH-1:0] Sdata,
   output logic                  Lgrant,
   output logic                  Egrant,
   output logic                  Sgrant,
`ifdef ARB_PKT_CNT_EN
   output logic [15:0]           pkt_count,
`endif
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  wr_en
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GNT_L = 2'd1,
      GNT_E = 2'd2,
      GNT_S = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      P_L = 2'd0,
      P_E = 2'd1,
      P_S = 2'd2
   } ptr_t;

   state_t state, state_n;
   ptr_t   ptr, ptr_n;
   logic   is_tail;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr   <= P_L;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
      end
   end

   // Grants follow the owner's req so an empty FIFO simply stalls the packet.
   always_comb begin
      Lgrant   = 1'b0;
      Egrant   = 1'b0;
      Sgrant   = 1'b0;
      data_out = '0;
      case (state)
         GNT_L: begin
            Lgrant   = Lreq;
            data_out = Ldata;
         end
         GNT_E: begin
            Egrant   = Ereq;
            data_out = Edata;
         end
         GNT_S: begin
            Sgrant   = Sreq;
            data_out = Sdata;
         end
         default: ;
      endcase
      if (rst) begin
         Lgrant = 1'b0;
         Egrant = 1'b0;
         Sgrant = 1'b0;
      end
      wr_en = Lgrant | Egrant | Sgrant;
   end

   assign is_tail = wr_en &&
      (data_out[DATA_WIDTH-1:DATA_WIDTH-3] == 3'b100);

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      case (state)
         IDLE: begin
            case (ptr)
               P_E: begin
                  if (Ereq) begin
                     state_n = GNT_E;
                     ptr_n   = P_S;
                  end else if (Sreq) begin
                     state_n = GNT_S;
                     ptr_n   = P_L;
                  end else if (Lreq) begin
                     state_n = GNT_L;
                     ptr_n   = P_E;
                  end
               end
               P_S: begin
                  if (Sreq) begin
                     state_n = GNT_S;
                     ptr_n   = P_L;
                  end else if (Lreq) begin
                     state_n = GNT_L;
                     ptr_n   = P_E;
                  end else if (Ereq) begin
                     state_n = GNT_E;
                     ptr_n   = P_S;
                  end
               end
               default: begin
                  if (Lreq) begin
                     state_n = GNT_L;
                     ptr_n   = P_E;
                  end else if (Ereq) begin
                     state_n = GNT_E;
                     ptr_n   = P_S;
                  end else if (Sreq) begin
                     state_n = GNT_S;
                     ptr_n   = P_L;
                  end
               end
            endcase
         end
         default: begin
            if (is_tail) state_n = IDLE;
         end
      endcase
   end

`ifdef ARB_PKT_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)          pkt_count <= 16'd0;
      else if (is_tail) pkt_count <= pkt_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_router_0_out_arbiter.sv
// Directed bench for router_0_out_arbiter.
// Checks arbitration order, stalls, reset abort and single-flit packets.
module tb_router_0_out_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        Lreq, Ereq, Sreq;
   logic [31:0] Ldata, Edata, Sdata;
   logic        Lgrant, Egrant, Sgrant;
   logic [31:0] data_out;
   logic        wr_en;
`ifdef ARB_PKT_CNT_EN
   logic [15:0] pkt_count;
`endif
   logic [3:0]  obs;

   int total = 0;
   int bad   = 0;

   router_0_out_arbiter #(.DATA_WIDTH(32)) dut (
      .clk      (clk),
      .rst      (rst),
      .Lreq     (Lreq),
      .Ereq     (Ereq),
      .Sreq     (Sreq),
      .Ldata    (Ldata),
      .Edata    (Edata),
      .Sdata    (Sdata),
      .Lgrant   (Lgrant),
      .Egrant   (Egrant),
      .Sgrant   (Sgrant),
`ifdef ARB_PKT_CNT_EN
      .pkt_count(pkt_count),
`endif
      .data_out (data_out),
      .wr_en    (wr_en)
   );

   always #5 clk = ~clk;

   assign obs = {Lgrant, Egrant, Sgrant, wr_en};

   localparam logic [31:0] LH = {3'b001, 29'h0A0001};
   localparam logic [31:0] LB = {3'b010, 29'h0A0002};
   localparam logic [31:0] LT = {3'b100, 29'h0A0003};
   localparam logic [31:0] EH = {3'b001, 29'h0E0001};
   localparam logic [31:0] EB = {3'b010, 29'h0E0002};
   localparam logic [31:0] ET = {3'b100, 29'h0E0003};
   localparam logic [31:0] SH = {3'b001, 29'h050001};
   localparam logic [31:0] SB = {3'b010, 29'h050002};
   localparam logic [31:0] ST = {3'b100, 29'h050003};

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst  = 1'b1;
      Lreq = 1'b0;
      Ereq = 1'b0;
      Sreq = 1'b0;
      Ldata = LH;
      Edata = EH;
      Sdata = SH;
      tick;
      tick;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset;
      rst  = 1'b1;
      Lreq = 1'b1;
      Ereq = 1'b1;
      Sreq = 1'b1;
      Ldata = LH;
      Edata = EH;
      Sdata = SH;
      tick;
      tick;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL reset_gnt got=%b want=0000", obs);
      end
      total++;
      if (data_out !== 32'h0) begin
         bad++;
         $display("FAIL reset_data got=%h want=0", data_out);
      end
      Lreq = 1'b0;
      Ereq = 1'b0;
      Sreq = 1'b0;
      rst  = 1'b0;
      tick;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL reset_idle got=%b want=0000", obs);
      end
   endtask

   task automatic test_basic;
      logic [31:0] fl [3];
      fl[0] = LH;
      fl[1] = LB;
      fl[2] = LT;
      do_reset;
      Lreq  = 1'b1;
      Ldata = LH;
      #1;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL basic_arb got=%b want=0000", obs);
      end
      for (int i = 0; i < 3; i++) begin
         tick;
         Ldata = fl[i];
         #1;
         total++;
         if (obs !== 4'b1001 || data_out !== fl[i]) begin
            bad++;
            $display("FAIL basic_flit%0d got=%b/%h want=1001/%h",
                     i, obs, data_out, fl[i]);
         end
      end
      tick;
      Lreq = 1'b0;
      #1;
      total++;
      if (obs !== 4'b0000 || data_out !== 32'h0) begin
         bad++;
         $display("FAIL basic_end got=%b/%h want=0000/0", obs, data_out);
      end
   endtask

   task automatic test_round_robin;
      logic [2:0] eg [13];
      logic       et [13];
      logic [31:0] ed;
      eg = '{3'b000, 3'b100, 3'b100, 3'b000, 3'b010, 3'b010, 3'b000,
             3'b001, 3'b001, 3'b000, 3'b100, 3'b100, 3'b000};
      et = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0};
      do_reset;
      Lreq = 1'b1;
      Ereq = 1'b1;
      Sreq = 1'b1;
      for (int i = 0; i < 13; i++) begin
         if (i > 0) tick;
         Ldata = (eg[i][2] && et[i]) ? LT : LH;
         Edata = (eg[i][1] && et[i]) ? ET : EH;
         Sdata = (eg[i][0] && et[i]) ? ST : SH;
         ed = eg[i][2] ? Ldata : eg[i][1] ? Edata :
              eg[i][0] ? Sdata : 32'h0;
         #1;
         total++;
         if (obs !== {eg[i], |eg[i]} || data_out !== ed) begin
            bad++;
            $display("FAIL rr_cyc%0d got=%b/%h want=%b/%h",
                     i, obs, data_out, {eg[i], |eg[i]}, ed);
         end
      end
      Lreq = 1'b0;
      Ereq = 1'b0;
      Sreq = 1'b0;
   endtask

   task automatic test_stall;
      do_reset;
      Ereq  = 1'b1;
      Edata = EH;
      tick;
      total++;
      if (obs !== 4'b0101 || data_out !== EH) begin
         bad++;
         $display("FAIL stall_head got=%b/%h want=0101/%h", obs, data_out, EH);
      end
      tick;
      Ereq  = 1'b0;
      Lreq  = 1'b1;
      Edata = EB;
      for (int i = 0; i < 5; i++) begin
         #1;
         total++;
         if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL stall_cyc%0d got=%b want=0000", i, obs);
         end
         tick;
      end
      Ereq = 1'b1;
      #1;
      total++;
      if (obs !== 4'b0101 || data_out !== EB) begin
         bad++;
         $display("FAIL stall_body got=%b/%h want=0101/%h", obs, data_out, EB);
      end
      tick;
      Edata = ET;
      #1;
      total++;
      if (obs !== 4'b0101 || data_out !== ET) begin
         bad++;
         $display("FAIL stall_tail got=%b/%h want=0101/%h", obs, data_out, ET);
      end
      tick;
      Ereq = 1'b0;
      Ldata = LT;
      #1;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL stall_bubble got=%b want=0000", obs);
      end
      tick;
      total++;
      if (obs !== 4'b1001 || data_out !== LT) begin
         bad++;
         $display("FAIL stall_next got=%b/%h want=1001/%h", obs, data_out, LT);
      end
      tick;
      Lreq = 1'b0;
   endtask

   task automatic test_reset_mid;
      do_reset;
      Sreq  = 1'b1;
      Sdata = SH;
      tick;
      total++;
      if (obs !== 4'b0011 || data_out !== SH) begin
         bad++;
         $display("FAIL rmid_head got=%b/%h want=0011/%h", obs, data_out, SH);
      end
      tick;
      Sdata = SB;
      rst   = 1'b1;
      #1;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL rmid_rst got=%b want=0000", obs);
      end
      tick;
      total++;
      if (obs !== 4'b0000 || data_out !== 32'h0) begin
         bad++;
         $display("FAIL rmid_idle got=%b/%h want=0000/0", obs, data_out);
      end
      rst  = 1'b0;
      Sreq = 1'b0;
      Ereq = 1'b1;
      Edata = EH;
      tick;
      total++;
      if (obs !== 4'b0101) begin
         bad++;
         $display("FAIL rmid_e got=%b want=0101", obs);
      end
      tick;
      Edata = EB;
      rst   = 1'b1;
      tick;
      rst  = 1'b0;
      Lreq = 1'b1;
      Sreq = 1'b1;
      Ldata = LH;
      Sdata = SH;
      #1;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL rmid_arb got=%b want=0000", obs);
      end
      tick;
      total++;
      if (obs !== 4'b1001) begin
         bad++;
         $display("FAIL rmid_ptr got=%b want=1001", obs);
      end
      Lreq = 1'b0;
      Ereq = 1'b0;
      Sreq = 1'b0;
   endtask

   task automatic test_single_flit;
      do_reset;
      Sreq  = 1'b1;
      Sdata = ST;
      tick;
      total++;
      if (obs !== 4'b0011 || data_out !== ST) begin
         bad++;
         $display("FAIL single_wr got=%b/%h want=0011/%h", obs, data_out, ST);
      end
      tick;
      Sdata = SH;
      #1;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL single_idle got=%b want=0000", obs);
      end
      Sreq = 1'b0;
      tick;
      total++;
      if (obs !== 4'b0000) begin
         bad++;
         $display("FAIL single_after got=%b want=0000", obs);
      end
   endtask

`ifdef ARB_PKT_CNT_EN
   task automatic test_pkt_count;
      do_reset;
      total++;
      if (pkt_count !== 16'd0) begin
         bad++;
         $display("FAIL cnt_reset got=%0d want=0", pkt_count);
      end
      Lreq  = 1'b1;
      Ldata = LT;
      for (int i = 0; i < 6; i++) tick;
      Lreq = 1'b0;
      #1;
      total++;
      if (pkt_count !== 16'd3) begin
         bad++;
         $display("FAIL cnt_three got=%0d want=3", pkt_count);
      end
   endtask
`endif

   initial begin
      rst  = 1'b1;
      Lreq = 1'b0;
      Ereq = 1'b0;
      Sreq = 1'b0;
      Ldata = '0;
      Edata = '0;
      Sdata = '0;
      test_reset;
      test_basic;
      test_round_robin;
      test_stall;
      test_reset_mid;
      test_single_flit;
`ifdef ARB_PKT_CNT_EN
      test_pkt_count;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
